serial_mag_comparator: RTL and testbench

- Multi-cycle, parametrised magnitude comparator.
- Compares two W-bit operands MSB-first, DIGIT bits per cycle, in signed (two's complement) or unsigned mode, with start/done handshake.
- Optional early exit at the first differing digit.
- Used where a wide compare must share a narrow datapath, or where fast one-hot compare results feed sequential control logic.

---
 rtl/serial_mag_comparator_if.sv | 26 ++
 rtl/serial_mag_comparator.sv | 137 +++++++++++++
 tb/tb_serial_mag_comparator.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_mag_comparator_if.sv
// Request/result bundle for serial_mag_comparator.
// The master drives the operands and the start/abort controls. The slave returns status and the one-hot result.
interface serial_mag_comparator_if #(
  parameter int W = 8
);
  logic         start;
  logic         abort;
  logic         signed_mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         agtb;
  logic         aeqb;
  logic         altb;

  modport master (
    output start, abort, signed_mode, a, b,
    input  busy, done, agtb, aeqb, altb
  );

  modport slave (
    input  start, abort, signed_mode, a, b,
    output busy, done, agtb, aeqb, altb
  );
endinterface

// File: rtl/serial_mag_comparator.sv
// Serial MSB-first magnitude comparator, DIGIT bits per cycle. A signed compare is done by flipping the operand sign bits.
// Decision k edges after start (k = digits examined), done the cycle after; start is ignored while busy, and abort cancels.
module serial_mag_comparator #(
  parameter int W          = 8,
  parameter int DIGIT      = 1,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_mag_comparator_if.slave cmp
);
  localparam int NDIG = W / DIGIT;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NDIG - 1);

  typedef enum logic {S_IDLE, S_CMP} state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [W-1:0]                r_a;
  logic [W-1:0]                r_b;
  logic [IDXW-1:0]             r_idx;
  logic                        r_done;
  logic                        r_agtb;
  logic                        r_aeqb;
  logic                        r_altb;
  logic                        r_diff_seen;
  logic                        r_diff_gt;

  logic [NDIG-1:0][DIGIT-1:0]  w_a_digs;
  logic [NDIG-1:0][DIGIT-1:0]  w_b_digs;
  logic [DIGIT-1:0]            w_dig_a;
  logic [DIGIT-1:0]            w_dig_b;
  logic                        w_dig_ne;
  logic                        w_dig_gt;
  logic                        w_load;
  logic                        w_step;
  logic                        w_finish;
  logic                        w_fin_gt;
  logic                        w_fin_eq;

  assign w_a_digs = r_a;
  assign w_b_digs = r_b;
  assign w_dig_a  = w_a_digs[r_idx];
  assign w_dig_b  = w_b_digs[r_idx];
  assign w_dig_ne = (w_dig_a != w_dig_b);
  assign w_dig_gt = (w_dig_a > w_dig_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Abort is checked first so it overrides any decision on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    w_fin_gt    = 1'b0;
    w_fin_eq    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmp.start) begin
          w_load      = 1'b1;
          w_state_nxt = S_CMP;
        end
      end
      S_CMP: begin
        if (cmp.abort) begin
          w_state_nxt = S_IDLE;
        end else if (EARLY_EXIT && w_dig_ne) begin
          w_finish    = 1'b1;
          w_fin_gt    = w_dig_gt;
          w_state_nxt = S_IDLE;
        end else if (r_idx == '0) begin
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
          if (r_diff_seen) begin
            w_fin_gt = r_diff_gt;
          end else if (w_dig_ne) begin
            w_fin_gt = w_dig_gt;
          end else begin
            w_fin_eq = 1'b1;
          end
        end else begin
          w_step = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_idx       <= '0;
      r_done      <= 1'b0;
      r_agtb      <= 1'b0;
      r_aeqb      <= 1'b0;
      r_altb      <= 1'b0;
      r_diff_seen <= 1'b0;
      r_diff_gt   <= 1'b0;
    end else begin
      r_done <= w_finish;
      // Offset-binary: flipping the sign bit turns a signed order into an unsigned one.
      if (w_load) begin
        r_a         <= {cmp.a[W-1] ^ cmp.signed_mode, cmp.a[W-2:0]};
        r_b         <= {cmp.b[W-1] ^ cmp.signed_mode, cmp.b[W-2:0]};
        r_idx       <= IDX_TOP;
        r_diff_seen <= 1'b0;
        r_diff_gt   <= 1'b0;
      end else if (w_step) begin
        r_idx <= r_idx - IDXW'(1);
        if (w_dig_ne && !r_diff_seen) begin
          r_diff_seen <= 1'b1;
          r_diff_gt   <= w_dig_gt;
        end
      end
      if (w_finish) begin
        r_agtb <= !w_fin_eq && w_fin_gt;
        r_aeqb <= w_fin_eq;
        r_altb <= !w_fin_eq && !w_fin_gt;
      end
    end
  end

  assign cmp.busy = (r_state == S_CMP);
  assign cmp.done = r_done;
  assign cmp.agtb = r_agtb;
  assign cmp.aeqb = r_aeqb;
  assign cmp.altb = r_altb;
endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed bench for serial_mag_comparator: one early-exit, one full-scan and one 4-bit-digit instance.
module tb_serial_mag_comparator;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  serial_mag_comparator_if #(.W(8)) if0 ();
  serial_mag_comparator_if #(.W(8)) if1 ();
  serial_mag_comparator_if #(.W(8)) if2 ();

  serial_mag_comparator #(.W(8), .DIGIT(1), .EARLY_EXIT(1'b1)) u_dut0 (.clk(clk), .rst(rst), .cmp(if0));
  serial_mag_comparator #(.W(8), .DIGIT(1), .EARLY_EXIT(1'b0)) u_dut1 (.clk(clk), .rst(rst), .cmp(if1));
  serial_mag_comparator #(.W(8), .DIGIT(4), .EARLY_EXIT(1'b1)) u_dut2 (.clk(clk), .rst(rst), .cmp(if2));

  logic       done_v [3];
  logic       busy_v [3];
  logic [2:0] res_v  [3];

  assign done_v[0] = if0.done;
  assign done_v[1] = if1.done;
  assign done_v[2] = if2.done;
  assign busy_v[0] = if0.busy;
  assign busy_v[1] = if1.busy;
  assign busy_v[2] = if2.busy;
  assign res_v[0]  = {if0.agtb, if0.aeqb, if0.altb};
  assign res_v[1]  = {if1.agtb, if1.aeqb, if1.altb};
  assign res_v[2]  = {if2.agtb, if2.aeqb, if2.altb};

  localparam logic [2:0] R_GT = 3'b100;
  localparam logic [2:0] R_EQ = 3'b010;
  localparam logic [2:0] R_LT = 3'b001;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic st, input logic [7:0] av, input logic [7:0] bv,
                       input logic sm);
    case (sel)
      0: begin if0.start = st; if0.a = av; if0.b = bv; if0.signed_mode = sm; end
      1: begin if1.start = st; if1.a = av; if1.b = bv; if1.signed_mode = sm; end
      default: begin if2.start = st; if2.a = av; if2.b = bv; if2.signed_mode = sm; end
    endcase
  endtask

  task automatic set_start(input int sel, input logic st);
    case (sel)
      0: if0.start = st;
      1: if1.start = st;
      default: if2.start = st;
    endcase
  endtask

  // k counts edges after E0; done seen after edge k means the decision was at Ek.
  task automatic wait_done(input int sel, input int k0, output int k);
    bit seen;
    seen = 1'b0;
    k = k0;
    while (!seen && k < k0 + 20) begin
      tick();
      k++;
      if (done_v[sel]) seen = 1'b1;
    end
  endtask

  task automatic do_cmp(input int sel, input logic [7:0] av, input logic [7:0] bv, input logic sm,
                        input int exp_k, input logic [2:0] exp_res, input string tag);
    int k;
    drive(sel, 1'b1, av, bv, sm);
    tick();
    set_start(sel, 1'b0);
    chk({tag, "_busy_after_start"}, 32'(busy_v[sel]), 32'd1);
    wait_done(sel, 0, k);
    chk({tag, "_k"}, 32'(k), 32'(exp_k));
    chk({tag, "_res"}, 32'(res_v[sel]), 32'(exp_res));
    chk({tag, "_busy_at_done"}, 32'(busy_v[sel]), 32'd0);
    tick();
    chk({tag, "_done_one_cycle"}, 32'(done_v[sel]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int done_cnt;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    if0.abort = 1'b0;
    if1.abort = 1'b0;
    if2.abort = 1'b0;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (2) tick();
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("reset_busy%0d", s), 32'(busy_v[s]), 32'd0);
      chk($sformatf("reset_done%0d", s), 32'(done_v[s]), 32'd0);
      chk($sformatf("reset_res%0d", s),  32'(res_v[s]),  32'd0);
    end
    rst = 1'b0;
    tick();

    do_cmp(0, 8'hF9, 8'hFD, 1'b1, 6, R_LT, "signed_m7_m3");
    do_cmp(0, 8'h80, 8'h7F, 1'b1, 1, R_LT, "sign_bnd_signed");
    do_cmp(0, 8'h80, 8'h7F, 1'b0, 1, R_GT, "sign_bnd_unsigned");
    do_cmp(0, 8'hFD, 8'hFD, 1'b0, 8, R_EQ, "equal_unsigned");
    do_cmp(0, 8'hFD, 8'hFD, 1'b1, 8, R_EQ, "equal_signed");
    do_cmp(1, 8'h80, 8'h7F, 1'b0, 8, R_GT, "noee_80_7f");
    do_cmp(1, 8'h01, 8'h02, 1'b0, 8, R_LT, "noee_01_02");
    do_cmp(1, 8'h42, 8'h42, 1'b1, 8, R_EQ, "noee_equal");
    do_cmp(2, 8'h3C, 8'h3A, 1'b0, 2, R_GT, "d4_3c_3a");
    do_cmp(2, 8'h5C, 8'h3A, 1'b0, 1, R_GT, "d4_5c_3a");
    do_cmp(2, 8'h80, 8'h7F, 1'b1, 1, R_LT, "d4_signed_bnd");

    // Abort on E3: no done, busy drops, previous equal result kept.
    drive(0, 1'b1, 8'h01, 8'h02, 1'b0);
    tick();
    set_start(0, 1'b0);
    tick();
    tick();
    if0.abort = 1'b1;
    tick();
    if0.abort = 1'b0;
    chk("abort_busy", 32'(busy_v[0]), 32'd0);
    chk("abort_done", 32'(done_v[0]), 32'd0);
    chk("abort_res_kept", 32'(res_v[0]), 32'(R_EQ));
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done_v[0]) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);

    // Start pulsed while busy with other operands must be ignored.
    drive(0, 1'b1, 8'h01, 8'h02, 1'b0);
    tick();
    set_start(0, 1'b0);
    tick();
    drive(0, 1'b1, 8'hFF, 8'h00, 1'b1);
    tick();
    set_start(0, 1'b0);
    wait_done(0, 2, k);
    chk("busy_start_k", 32'(k), 32'd7);
    chk("busy_start_res", 32'(res_v[0]), 32'(R_LT));
    tick();

    // Back-to-back: new start in the done cycle.
    drive(0, 1'b1, 8'h80, 8'h7F, 1'b0);
    tick();
    set_start(0, 1'b0);
    tick();
    chk("b2b_first_done", 32'(done_v[0]), 32'd1);
    chk("b2b_first_res", 32'(res_v[0]), 32'(R_GT));
    drive(0, 1'b1, 8'hF9, 8'hFD, 1'b1);
    tick();
    set_start(0, 1'b0);
    chk("b2b_second_busy", 32'(busy_v[0]), 32'd1);
    chk("b2b_second_done_low", 32'(done_v[0]), 32'd0);
    chk("b2b_res_held", 32'(res_v[0]), 32'(R_GT));
    wait_done(0, 0, k);
    chk("b2b_second_k", 32'(k), 32'd6);
    chk("b2b_second_res", 32'(res_v[0]), 32'(R_LT));
    tick();

    // Asynchronous reset in the middle of a compare.
    drive(0, 1'b1, 8'h01, 8'h02, 1'b0);
    tick();
    set_start(0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(busy_v[0]), 32'd0);
    chk("rst_mid_done", 32'(done_v[0]), 32'd0);
    chk("rst_mid_res", 32'(res_v[0]), 32'd0);
    chk("rst_mid_res_noee", 32'(res_v[1]), 32'd0);
    #1;
    rst = 1'b0;
    tick();
    do_cmp(0, 8'hFD, 8'hF9, 1'b0, 6, R_GT, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
